// File: rtl/trace_checker_pkg.sv
// Shared types and widths for the CPU writeback trace checker.
// Holds the checker state encoding, the trace field widths and the
// golden-entry layout stored in the trace FIFO.
package trace_checker_pkg;

  localparam int PC_W   = 32;
  localparam int WNUM_W = 5;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FAIL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WNUM_W-1:0] wnum;
    logic [DATA_W-1:0] wdata;
  } gold_entry_t;

  localparam int ENTRY_W = $bits(gold_entry_t);

  // Byte-lane compare: only lanes whose write enable is set take part.
  function automatic logic masked_data_eq(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic [WE_W-1:0]   we);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < WE_W; i++) begin
      if (we[i] && (a[8*i +: 8] != b[8*i +: 8])) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/trace_checker_if.sv
// Bundle of the golden-entry push handshake and the CPU writeback trace.
// The master side is the trace source (bench or CPU wrapper); the slave
// side is the checker.
interface trace_checker_if;
  import trace_checker_pkg::*;

  logic              gold_valid;
  logic              gold_ready;
  logic [PC_W-1:0]   gold_pc;
  logic [WNUM_W-1:0] gold_wnum;
  logic [DATA_W-1:0] gold_wdata;

  logic [PC_W-1:0]   debug_wb_pc;
  logic [WE_W-1:0]   debug_wb_rf_we;
  logic [WNUM_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;

  modport master (
    output gold_valid, gold_pc, gold_wnum, gold_wdata,
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  gold_ready
  );

  modport slave (
    input  gold_valid, gold_pc, gold_wnum, gold_wdata,
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output gold_ready
  );

endinterface

// File: rtl/trace_checker_fifo.sv
// Synchronous FIFO holding golden trace entries.
// The head is presented combinationally so the checker can compare in the
// same cycle it pops. A write and a read may happen together; the entry
// written this cycle is never visible to a read in the same cycle because
// emptiness is judged from the registered level.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem[rptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Pointer and level bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer/level registers; reset discards contents by zeroing them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Entry storage; not reset since stale data is unreachable once cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/trace_checker.sv
// Writeback trace checker: compares each CPU register-file writeback
// against the next golden entry and stops in FAIL on the first divergence
// or underflow, or in DONE once the end PC retires cleanly.
module trace_checker
  import trace_checker_pkg::*;
#(
  parameter int              DEPTH  = 8,
  parameter logic [PC_W-1:0] END_PC = 32'h1c00_0100
) (
  input  logic                    clk,
  input  logic                    reset,
  trace_checker_if.slave          bus,
  output logic                    done,
  output logic                    mismatch,
  output logic                    underflow,
  output logic [31:0]             pass_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [PC_W-1:0]         err_pc,
  output logic [PC_W-1:0]         err_exp_pc,
  output logic [WNUM_W-1:0]       err_exp_wnum,
  output logic [DATA_W-1:0]       err_exp_wdata,
  output logic [DATA_W-1:0]       err_got_wdata
);

  state_t            state_q, state_d;
  gold_entry_t       head;
  gold_entry_t       push_entry;
  logic [ENTRY_W-1:0] head_raw;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              trace_event;
  logic              cmp_ok;
  logic              pc_hit;

  logic              mismatch_q, mismatch_d;
  logic              underflow_q, underflow_d;
  logic [31:0]       pass_cnt_q, pass_cnt_d;
  logic [PC_W-1:0]   err_pc_q, err_pc_d;
  logic [PC_W-1:0]   err_exp_pc_q, err_exp_pc_d;
  logic [WNUM_W-1:0] err_exp_wnum_q, err_exp_wnum_d;
  logic [DATA_W-1:0] err_exp_wdata_q, err_exp_wdata_d;
  logic [DATA_W-1:0] err_got_wdata_q, err_got_wdata_d;

  assign push_entry = '{pc: bus.gold_pc, wnum: bus.gold_wnum, wdata: bus.gold_wdata};
  assign head       = head_raw;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.gold_valid),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_raw),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign bus.gold_ready = !fifo_full;

  assign trace_event = (bus.debug_wb_rf_we != '0) && (bus.debug_wb_rf_wnum != '0);
  assign pc_hit      = (bus.debug_wb_pc == END_PC);
  assign cmp_ok      = (bus.debug_wb_pc == head.pc) &&
                       (bus.debug_wb_rf_wnum == head.wnum) &&
                       masked_data_eq(head.wdata, bus.debug_wb_rf_wdata, bus.debug_wb_rf_we);

  // State register for the RUN/FAIL/DONE checker FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: failure outranks reaching the end PC in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (trace_event) begin
          if (fifo_empty || !cmp_ok) state_d = ST_FAIL;
          else if (pc_hit)           state_d = ST_DONE;
        end else if (pc_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: pop only while running, and done is the DONE state itself.
  always_comb begin
    fifo_pop = (state_q == ST_RUN) && trace_event && !fifo_empty;
    done     = (state_q == ST_DONE);
  end

  // Flags, pass counter and error capture; all frozen outside RUN.
  always_comb begin
    mismatch_d      = mismatch_q;
    underflow_d     = underflow_q;
    pass_cnt_d      = pass_cnt_q;
    err_pc_d        = err_pc_q;
    err_exp_pc_d    = err_exp_pc_q;
    err_exp_wnum_d  = err_exp_wnum_q;
    err_exp_wdata_d = err_exp_wdata_q;
    err_got_wdata_d = err_got_wdata_q;
    if ((state_q == ST_RUN) && trace_event) begin
      if (fifo_empty) begin
        underflow_d     = 1'b1;
        err_pc_d        = bus.debug_wb_pc;
        err_got_wdata_d = bus.debug_wb_rf_wdata;
        err_exp_pc_d    = '0;
        err_exp_wnum_d  = '0;
        err_exp_wdata_d = '0;
      end else if (!cmp_ok) begin
        mismatch_d      = 1'b1;
        err_pc_d        = bus.debug_wb_pc;
        err_got_wdata_d = bus.debug_wb_rf_wdata;
        err_exp_pc_d    = head.pc;
        err_exp_wnum_d  = head.wnum;
        err_exp_wdata_d = head.wdata;
      end else begin
        pass_cnt_d = pass_cnt_q + 32'd1;
      end
    end
  end

  // Registers behind the flags, counter and error capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_q      <= 1'b0;
      underflow_q     <= 1'b0;
      pass_cnt_q      <= '0;
      err_pc_q        <= '0;
      err_exp_pc_q    <= '0;
      err_exp_wnum_q  <= '0;
      err_exp_wdata_q <= '0;
      err_got_wdata_q <= '0;
    end else begin
      mismatch_q      <= mismatch_d;
      underflow_q     <= underflow_d;
      pass_cnt_q      <= pass_cnt_d;
      err_pc_q        <= err_pc_d;
      err_exp_pc_q    <= err_exp_pc_d;
      err_exp_wnum_q  <= err_exp_wnum_d;
      err_exp_wdata_q <= err_exp_wdata_d;
      err_got_wdata_q <= err_got_wdata_d;
    end
  end

  assign mismatch      = mismatch_q;
  assign underflow     = underflow_q;
  assign pass_cnt      = pass_cnt_q;
  assign err_pc        = err_pc_q;
  assign err_exp_pc    = err_exp_pc_q;
  assign err_exp_wnum  = err_exp_wnum_q;
  assign err_exp_wdata = err_exp_wdata_q;
  assign err_got_wdata = err_got_wdata_q;

endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker. A behavioural model of the golden
// FIFO and checker state predicts the outcome of every driven cycle; the
// prediction is queued and each scenario task pops it and compares.
module tb_trace_checker;
  import trace_checker_pkg::*;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] END_PC = 32'h1c00_0100;
  localparam int          LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          done, mismatch, underflow;
  logic [31:0]   pass_cnt;
  logic [LW-1:0] fifo_level;
  logic [31:0]   err_pc, err_exp_pc, err_exp_wdata, err_got_wdata;
  logic [4:0]    err_exp_wnum;

  trace_checker_if bus();

  trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done), .mismatch(mismatch), .underflow(underflow),
    .pass_cnt(pass_cnt), .fifo_level(fifo_level),
    .err_pc(err_pc), .err_exp_pc(err_exp_pc), .err_exp_wnum(err_exp_wnum),
    .err_exp_wdata(err_exp_wdata), .err_got_wdata(err_got_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   passCnt;
    logic [LW-1:0] level;
    logic          mis, und, dn, ready;
    logic [31:0]   errPc, errExpPc, errExpWdata, errGotWdata;
    logic [4:0]    errExpWnum;
  } exp_t;

  gold_entry_t modelQ[$];
  exp_t        expQ[$];
  exp_t        e;
  int          mState;
  logic [31:0] mPass, mErrPc, mErrExpPc, mErrExpWdata, mErrGotWdata;
  logic [4:0]  mErrExpWnum;
  logic        mMis, mUnd;
  int          testsRun = 0;
  int          testsFailed = 0;

  // Quiet bus: no push, no writeback, pc far from END_PC.
  task automatic applyIdle();
    bus.gold_valid = 1'b0; bus.gold_pc = '0; bus.gold_wnum = '0; bus.gold_wdata = '0;
    bus.debug_wb_pc = '0; bus.debug_wb_rf_we = '0; bus.debug_wb_rf_wnum = '0; bus.debug_wb_rf_wdata = '0;
  endtask

  task automatic modelClear();
    modelQ.delete(); expQ.delete();
    mState = 0; mPass = '0; mMis = 0; mUnd = 0;
    mErrPc = '0; mErrExpPc = '0; mErrExpWnum = '0; mErrExpWdata = '0; mErrGotWdata = '0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyIdle();
    modelClear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic gold_entry_t mkEntry(input int idx);
    gold_entry_t g;
    g.pc    = 32'h1c00_0000 + 32'(4 * idx);
    g.wnum  = 5'((idx % 31) + 1);
    g.wdata = $urandom;
    return g;
  endfunction

  // Drive one cycle (called at a negedge), predict its effect, queue the
  // prediction, and return at the next negedge with the bus idled.
  task automatic applyStimulus(input bit push, input gold_entry_t g,
                               input logic [31:0] pc, input logic [3:0] we,
                               input logic [4:0] wnum, input logic [31:0] wdata);
    gold_entry_t h;
    exp_t        x;
    logic [31:0] mask;
    bit          isEv, pushOk;
    bus.gold_valid = push; bus.gold_pc = g.pc; bus.gold_wnum = g.wnum; bus.gold_wdata = g.wdata;
    bus.debug_wb_pc = pc; bus.debug_wb_rf_we = we; bus.debug_wb_rf_wnum = wnum; bus.debug_wb_rf_wdata = wdata;
    isEv   = (we != 0) && (wnum != 0);
    pushOk = push && (modelQ.size() < DEPTH);
    mask   = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    if (mState == 0) begin
      if (isEv) begin
        if (modelQ.size() == 0) begin
          mUnd = 1; mErrPc = pc; mErrGotWdata = wdata;
          mErrExpPc = '0; mErrExpWnum = '0; mErrExpWdata = '0; mState = 1;
        end else begin
          h = modelQ.pop_front();
          if (h.pc == pc && h.wnum == wnum && ((h.wdata ^ wdata) & mask) == 0) begin
            mPass = mPass + 1;
            if (pc == END_PC) mState = 2;
          end else begin
            mMis = 1; mErrPc = pc; mErrGotWdata = wdata;
            mErrExpPc = h.pc; mErrExpWnum = h.wnum; mErrExpWdata = h.wdata; mState = 1;
          end
        end
      end else if (pc == END_PC) begin
        mState = 2;
      end
    end
    if (pushOk) modelQ.push_back(g);
    x.passCnt = mPass; x.level = LW'(modelQ.size()); x.mis = mMis; x.und = mUnd;
    x.dn = (mState == 2); x.ready = (modelQ.size() < DEPTH);
    x.errPc = mErrPc; x.errExpPc = mErrExpPc; x.errExpWnum = mErrExpWnum;
    x.errExpWdata = mErrExpWdata; x.errGotWdata = mErrGotWdata;
    expQ.push_back(x);
    @(posedge clk);
    @(negedge clk);
    applyIdle();
  endtask

  task automatic pushOnly(input gold_entry_t g);
    applyStimulus(1'b1, g, 32'h0, 4'h0, 5'd0, 32'h0);
  endtask

  // Event that replays the current model head, so it should match.
  task automatic matchHead(input bit push, input gold_entry_t g);
    gold_entry_t h;
    h = modelQ[0];
    applyStimulus(push, g, h.pc, 4'hF, h.wnum, h.wdata);
  endtask

  task automatic test_reset();
    resetDut();
    testsRun++; if ({done, mismatch, underflow} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags got %b expected 000", {done, mismatch, underflow}); end
    testsRun++; if (pass_cnt !== 32'd0 || fifo_level !== '0) begin testsFailed++; $display("[TB] FAIL reset_counts got pass=%0d level=%0d expected 0/0", pass_cnt, fifo_level); end
    testsRun++; if ({err_pc, err_exp_pc, err_exp_wdata, err_got_wdata, err_exp_wnum} !== '0) begin testsFailed++; $display("[TB] FAIL reset_err got pc=%h exp_pc=%h expected 0", err_pc, err_exp_pc); end
    testsRun++; if (bus.gold_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready got %b expected 1", bus.gold_ready); end
  endtask

  task automatic test_basic_match();
    gold_entry_t g;
    resetDut();
    for (int i = 0; i < 3; i++) begin
      g.pc = 32'h1c00_0000 + 32'(4 * i); g.wnum = 5'(i + 1); g.wdata = $urandom;
      pushOnly(g); e = expQ.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      matchHead(1'b0, g); e = expQ.pop_front();
      testsRun++; if (pass_cnt !== e.passCnt || mismatch !== e.mis) begin testsFailed++; $display("[TB] FAIL basic_event%0d got pass=%0d mis=%b expected pass=%0d mis=%b", i, pass_cnt, mismatch, e.passCnt, e.mis); end
    end
    testsRun++; if (pass_cnt !== 32'd3 || fifo_level !== '0 || mismatch !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_final got pass=%0d level=%0d mis=%b expected 3/0/0", pass_cnt, fifo_level, mismatch); end
  endtask

  task automatic test_byte_mask();
    gold_entry_t g;
    resetDut();
    g = '{pc: 32'h1c00_0020, wnum: 5'd4, wdata: 32'hFFFF_5678};
    pushOnly(g); e = expQ.pop_front();
    pushOnly(g); e = expQ.pop_front();
    applyStimulus(1'b0, g, 32'h1c00_0020, 4'b0011, 5'd4, 32'h1234_5678); e = expQ.pop_front();
    testsRun++; if (mismatch !== e.mis || pass_cnt !== e.passCnt) begin testsFailed++; $display("[TB] FAIL mask_partial got mis=%b pass=%0d expected mis=%b pass=%0d", mismatch, pass_cnt, e.mis, e.passCnt); end
    applyStimulus(1'b0, g, 32'h1c00_0020, 4'b1111, 5'd4, 32'h1234_5678); e = expQ.pop_front();
    testsRun++; if (mismatch !== e.mis || err_got_wdata !== e.errGotWdata) begin testsFailed++; $display("[TB] FAIL mask_full got mis=%b got_wdata=%h expected mis=%b got_wdata=%h", mismatch, err_got_wdata, e.mis, e.errGotWdata); end
    testsRun++; if (err_exp_wdata !== e.errExpWdata || err_exp_pc !== e.errExpPc || err_exp_wnum !== e.errExpWnum || err_pc !== e.errPc) begin testsFailed++; $display("[TB] FAIL mask_err got pc=%h exp_pc=%h wnum=%0d exp_wdata=%h expected %h/%h/%0d/%h", err_pc, err_exp_pc, err_exp_wnum, err_exp_wdata, e.errPc, e.errExpPc, e.errExpWnum, e.errExpWdata); end
  endtask

  task automatic test_underflow();
    gold_entry_t g;
    resetDut();
    g = mkEntry(5);
    applyStimulus(1'b0, g, 32'h1c00_0010, 4'hF, 5'd3, 32'hA5A5_0001); e = expQ.pop_front();
    testsRun++; if (underflow !== e.und || err_pc !== e.errPc || err_got_wdata !== e.errGotWdata) begin testsFailed++; $display("[TB] FAIL underflow_flag got und=%b pc=%h wdata=%h expected und=%b pc=%h wdata=%h", underflow, err_pc, err_got_wdata, e.und, e.errPc, e.errGotWdata); end
    testsRun++; if ({err_exp_pc, err_exp_wdata, err_exp_wnum} !== '0 || mismatch !== 1'b0) begin testsFailed++; $display("[TB] FAIL underflow_exp_zero got exp_pc=%h mis=%b expected 0/0", err_exp_pc, mismatch); end
    pushOnly(g); e = expQ.pop_front();
    applyStimulus(1'b0, g, g.pc, 4'hF, g.wnum, g.wdata); e = expQ.pop_front();
    testsRun++; if (pass_cnt !== e.passCnt || fifo_level !== e.level || err_pc !== e.errPc || done !== e.dn) begin testsFailed++; $display("[TB] FAIL underflow_frozen got pass=%0d level=%0d pc=%h done=%b expected %0d/%0d/%h/%b", pass_cnt, fifo_level, err_pc, done, e.passCnt, e.level, e.errPc, e.dn); end
  endtask

  task automatic test_fill_and_simul();
    gold_entry_t g;
    resetDut();
    for (int i = 0; i < DEPTH; i++) begin pushOnly(mkEntry(i)); e = expQ.pop_front(); end
    testsRun++; if (bus.gold_ready !== e.ready || fifo_level !== e.level) begin testsFailed++; $display("[TB] FAIL fill_full got ready=%b level=%0d expected ready=%b level=%0d", bus.gold_ready, fifo_level, e.ready, e.level); end
    pushOnly(mkEntry(20)); e = expQ.pop_front();
    testsRun++; if (fifo_level !== e.level) begin testsFailed++; $display("[TB] FAIL fill_overpush got level=%0d expected %0d", fifo_level, e.level); end
    for (int i = 0; i < 4; i++) begin matchHead(1'b0, g); e = expQ.pop_front(); end
    g = mkEntry(9);
    matchHead(1'b1, g); e = expQ.pop_front();
    testsRun++; if (fifo_level !== e.level || bus.gold_ready !== e.ready) begin testsFailed++; $display("[TB] FAIL simul_level4 got level=%0d ready=%b expected level=%0d ready=%b", fifo_level, bus.gold_ready, e.level, e.ready); end
    while (modelQ.size() > 0) begin
      matchHead(1'b0, g); e = expQ.pop_front();
      testsRun++; if (mismatch !== e.mis || pass_cnt !== e.passCnt || fifo_level !== e.level) begin testsFailed++; $display("[TB] FAIL simul_drain got mis=%b pass=%0d level=%0d expected mis=%b pass=%0d level=%0d", mismatch, pass_cnt, fifo_level, e.mis, e.passCnt, e.level); end
    end
  endtask

  task automatic test_back_to_back();
    gold_entry_t g;
    resetDut();
    pushOnly(mkEntry(1)); e = expQ.pop_front();
    g = mkEntry(2);
    matchHead(1'b1, g); e = expQ.pop_front();
    testsRun++; if (fifo_level !== e.level || pass_cnt !== e.passCnt) begin testsFailed++; $display("[TB] FAIL b2b_level1 got level=%0d pass=%0d expected level=%0d pass=%0d", fifo_level, pass_cnt, e.level, e.passCnt); end
    matchHead(1'b0, g); e = expQ.pop_front();
    testsRun++; if (mismatch !== e.mis || pass_cnt !== e.passCnt || fifo_level !== e.level) begin testsFailed++; $display("[TB] FAIL b2b_order got mis=%b pass=%0d level=%0d expected mis=%b pass=%0d level=%0d", mismatch, pass_cnt, fifo_level, e.mis, e.passCnt, e.level); end
  endtask

  task automatic test_done();
    gold_entry_t g;
    resetDut();
    g = '{pc: END_PC, wnum: 5'd7, wdata: 32'hCAFE_BABE};
    pushOnly(g); e = expQ.pop_front();
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL done_early got %b expected 0", done); end
    applyStimulus(1'b0, g, END_PC, 4'hF, 5'd7, 32'hCAFE_BABE); e = expQ.pop_front();
    testsRun++; if (done !== e.dn || pass_cnt !== e.passCnt || mismatch !== e.mis) begin testsFailed++; $display("[TB] FAIL done_match got done=%b pass=%0d mis=%b expected done=%b pass=%0d mis=%b", done, pass_cnt, mismatch, e.dn, e.passCnt, e.mis); end
    pushOnly(mkEntry(3)); e = expQ.pop_front();
    applyStimulus(1'b0, g, 32'h1c00_0000, 4'hF, 5'd1, 32'h0); e = expQ.pop_front();
    testsRun++; if (done !== e.dn || pass_cnt !== e.passCnt || mismatch !== e.mis || underflow !== e.und || fifo_level !== e.level) begin testsFailed++; $display("[TB] FAIL done_frozen got done=%b pass=%0d mis=%b und=%b level=%0d expected %b/%0d/%b/%b/%0d", done, pass_cnt, mismatch, underflow, fifo_level, e.dn, e.passCnt, e.mis, e.und, e.level); end
    resetDut();
    pushOnly(g); e = expQ.pop_front();
    applyStimulus(1'b0, g, END_PC, 4'hF, 5'd7, 32'hDEAD_BEEF); e = expQ.pop_front();
    repeat (2) begin applyStimulus(1'b0, g, 32'h0, 4'h0, 5'd0, 32'h0); e = expQ.pop_front(); end
    testsRun++; if (mismatch !== e.mis || done !== e.dn || err_exp_wdata !== e.errExpWdata) begin testsFailed++; $display("[TB] FAIL done_fail_priority got mis=%b done=%b exp_wdata=%h expected mis=%b done=%b exp_wdata=%h", mismatch, done, err_exp_wdata, e.mis, e.dn, e.errExpWdata); end
  endtask

  task automatic test_mid_reset();
    gold_entry_t g;
    resetDut();
    for (int i = 0; i < DEPTH; i++) begin pushOnly(mkEntry(i)); e = expQ.pop_front(); end
    for (int i = 0; i < 7; i++) begin matchHead(1'b0, g); e = expQ.pop_front(); end
    for (int i = 0; i < 4; i++) begin pushOnly(mkEntry(10 + i)); e = expQ.pop_front(); end
    testsRun++; if (fifo_level !== e.level || pass_cnt !== e.passCnt) begin testsFailed++; $display("[TB] FAIL midrst_pre got level=%0d pass=%0d expected level=%0d pass=%0d", fifo_level, pass_cnt, e.level, e.passCnt); end
    reset = 1'b1;
    #2;
    testsRun++; if ({done, mismatch, underflow} !== 3'b000 || pass_cnt !== 32'd0 || fifo_level !== '0 || err_pc !== '0) begin testsFailed++; $display("[TB] FAIL midrst_async got flags=%b pass=%0d level=%0d err_pc=%h expected all 0", {done, mismatch, underflow}, pass_cnt, fifo_level, err_pc); end
    modelClear();
    @(negedge clk);
    reset = 1'b0;
    testsRun++; if (bus.gold_ready !== 1'b1 || fifo_level !== '0) begin testsFailed++; $display("[TB] FAIL midrst_ready got ready=%b level=%0d expected 1/0", bus.gold_ready, fifo_level); end
    applyStimulus(1'b0, g, 32'h1c00_0000, 4'hF, 5'd1, 32'h1111_2222); e = expQ.pop_front();
    testsRun++; if (underflow !== e.und || mismatch !== e.mis || pass_cnt !== e.passCnt) begin testsFailed++; $display("[TB] FAIL midrst_discard got und=%b mis=%b pass=%0d expected und=%b mis=%b pass=%0d", underflow, mismatch, pass_cnt, e.und, e.mis, e.passCnt); end
  endtask

  initial begin
    reset = 1'b0;
    applyIdle();
    modelClear();
    test_reset();
    test_basic_match();
    test_byte_mask();
    test_underflow();
    test_fill_and_simul();
    test_back_to_back();
    test_done();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
